mul_share_ctrl: RTL and testbench

- Time-shares one combinational IEEE-754 single-precision multiplier among N_REQ requesters, e.g. the Maxnet neuron update lanes computing eps*sum.
- Per-requester valid/ready request handshake; round-robin grant.
- Registers the operands that drive the multiplier and waits a programmable settle time.
- Returns the captured product and overflow flag over a shared response channel with backpressure.

---
 rtl/mul_share_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter that time-shares one combinational FP32 multiplier among
// N_REQ requesters, holding registered operands for MUL_LAT cycles per operation.
module mul_share_ctrl #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_out,
    input  logic                  mul_ovf,
    output logic                  resp_valid,
    output logic [2:0]            resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_ovf,
    input  logic                  resp_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      ovf_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned LAT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_ovf_q, resp_ovf_d;
    logic [CNT_W-1:0]    ovf_count_q, ovf_count_d;

    logic [2*N_REQ-1:0]  valid_dbl;
    logic [2*N_REQ-1:0]  valid_rot;
    logic [ID_W:0]       idx_sum;
    logic [ID_W-1:0]     grant_c;
    logic                grant_vld_c;
    logic [DATA_W-1:0]   op_a_c;
    logic [DATA_W-1:0]   op_b_c;

    // Round-robin search starting at rr_q: rotate valids so bit 0 is rr_q.
    always_comb begin
        valid_dbl   = {req_valid, req_valid};
        valid_rot   = valid_dbl >> rr_q;
        idx_sum     = '0;
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_vld_c && valid_rot[k]) begin
                idx_sum = {1'b0, rr_q} + (ID_W+1)'(k);
                if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                    idx_sum = idx_sum - (ID_W+1)'(N_REQ);
                end
                grant_c     = idx_sum[ID_W-1:0];
                grant_vld_c = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        op_a_c = '0;
        op_b_c = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (grant_c == ID_W'(j)) begin
                op_a_c = req_a[j*DATA_W +: DATA_W];
                op_b_c = req_b[j*DATA_W +: DATA_W];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_ovf_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_ovf_q  <= resp_ovf_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_ovf_d  = resp_ovf_q;
        ovf_count_d = ovf_count_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    mul_a_d   = op_a_c;
                    mul_b_d   = op_b_c;
                    resp_id_d = grant_c;
                    cnt_d     = LAT_W'(MUL_LAT - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    resp_data_d = mul_out;
                    resp_ovf_d  = mul_ovf;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rr_d    = (resp_id_q == ID_W'(N_REQ - 1)) ? '0 : resp_id_q + ID_W'(1);
                    if (resp_ovf_q && (ovf_count_q != {CNT_W{1'b1}})) begin
                        ovf_count_d = ovf_count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational handshake/status outputs.
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        if (state_q == IDLE && grant_vld_c) begin
            req_ready = N_REQ'(1) << grant_c;
        end
        if (state_q == RESP) begin
            resp_valid = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign resp_id   = resp_id_q;
    assign resp_data = resp_data_q;
    assign resp_ovf  = resp_ovf_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: one instance at MUL_LAT=1/CNT_W=16, one at
// MUL_LAT=3/CNT_W=2 for latency and counter saturation.
module tb_mul_share_ctrl;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 1: MUL_LAT=1, CNT_W=16
    logic [N-1:0]    v1, rdy1;
    logic [32*N-1:0] a1, b1;
    logic [31:0]     ma1, mb1, mo1, rd1;
    logic            mov1, rv1, rov1, rr1, busy1;
    logic [2:0]      rid1;
    logic [15:0]     oc1;

    // Instance 2: MUL_LAT=3, CNT_W=2
    logic [N-1:0]    v2, rdy2;
    logic [32*N-1:0] a2, b2;
    logic [31:0]     ma2, mb2, mo2, rd2;
    logic            mov2, rv2, rov2, rr2, busy2;
    logic [2:0]      rid2;
    logic [1:0]      oc2;

    mul_share_ctrl #(.N_REQ(N), .MUL_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rdy1), .mul_a(ma1), .mul_b(mb1), .mul_out(mo1), .mul_ovf(mov1),
        .resp_valid(rv1), .resp_id(rid1), .resp_data(rd1), .resp_ovf(rov1),
        .resp_ready(rr1), .busy(busy1), .ovf_count(oc1)
    );

    mul_share_ctrl #(.N_REQ(N), .MUL_LAT(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_a(a2), .req_b(b2),
        .req_ready(rdy2), .mul_a(ma2), .mul_b(mb2), .mul_out(mo2), .mul_ovf(mov2),
        .resp_valid(rv2), .resp_id(rid2), .resp_data(rd2), .resp_ovf(rov2),
        .resp_ready(rr2), .busy(busy2), .ovf_count(oc2)
    );

    typedef struct {
        int unsigned id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        logic        ovf;
        logic [15:0] cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One MUL_LAT=3 transaction on instance 2, product held across CALC.
    task automatic op2(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] prod, input logic ovf,
                       input logic [1:0] cnt_before, input logic [1:0] cnt_after);
        v2 = 4'(1) << id;
        a2 = '0; b2 = '0;
        a2[32*id +: 32] = a;
        b2[32*id +: 32] = b;
        #1 chk("l3_ready", 32'(rdy2), 32'(4'(1) << id));
        tick();
        v2 = '0; mo2 = prod; mov2 = ovf;
        tick(); tick(); tick();
        mo2 = 32'h0; mov2 = 1'b0;
        #1;
        chk("l3_resp_valid", 32'(rv2), 32'd1);
        chk("l3_resp_data", rd2, prod);
        chk("l3_resp_ovf", 32'(rov2), 32'(ovf));
        chk("l3_cnt_before", 32'(oc2), 32'(cnt_before));
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
        #1;
        chk("l3_cnt_after", 32'(oc2), 32'(cnt_after));
        chk("l3_idle", 32'(busy2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[4];
        logic [15:0] prev_cnt;
        int         exp_ord[6];
        int         ng, last;

        tbl[0] = '{id: 2, a: 32'h40000000, b: 32'h40400000, prod: 32'h40C00000, ovf: 1'b0, cnt: 16'd0};
        tbl[1] = '{id: 0, a: 32'h00000000, b: 32'h40400000, prod: 32'h00000000, ovf: 1'b0, cnt: 16'd0};
        tbl[2] = '{id: 1, a: 32'h7F800000, b: 32'h3F800000, prod: 32'h7F800000, ovf: 1'b1, cnt: 16'd1};
        tbl[3] = '{id: 3, a: 32'h3F800000, b: 32'hC0000000, prod: 32'hC0000000, ovf: 1'b0, cnt: 16'd1};
        exp_ord = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        v1 = '0; a1 = '0; b1 = '0; mo1 = '0; mov1 = 1'b0; rr1 = 1'b0;
        v2 = '0; a2 = '0; b2 = '0; mo2 = '0; mov2 = 1'b0; rr2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_resp_valid", 32'(rv1), 32'd0);
        chk("rst_req_ready", 32'(rdy1), 32'd0);
        chk("rst_mul_a", ma1, 32'd0);
        chk("rst_mul_b", mb1, 32'd0);
        chk("rst_resp_data", rd1, 32'd0);
        chk("rst_resp_id", 32'(rid1), 32'd0);
        chk("rst_ovf_count", 32'(oc1), 32'd0);
        chk("rst_ovf_count2", 32'(oc2), 32'd0);

        // Single-requester operations, MUL_LAT=1.
        prev_cnt = 16'd0;
        for (int i = 0; i < 4; i++) begin
            v1 = 4'(1) << tbl[i].id;
            a1 = '0; b1 = '0;
            a1[32*tbl[i].id +: 32] = tbl[i].a;
            b1[32*tbl[i].id +: 32] = tbl[i].b;
            mo1 = 32'hDEADBEEF; mov1 = 1'b0; rr1 = 1'b0;
            #1;
            chk("vec_ready", 32'(rdy1), 32'(4'(1) << tbl[i].id));
            chk("vec_busy0", 32'(busy1), 32'd0);
            tick();
            v1 = '0; mo1 = tbl[i].prod; mov1 = tbl[i].ovf;
            #1;
            chk("vec_busy1", 32'(busy1), 32'd1);
            chk("vec_calc_rv", 32'(rv1), 32'd0);
            chk("vec_mul_a", ma1, tbl[i].a);
            chk("vec_mul_b", mb1, tbl[i].b);
            tick();
            mo1 = 32'h0; mov1 = 1'b0;
            #1;
            chk("vec_resp_valid", 32'(rv1), 32'd1);
            chk("vec_resp_id", 32'(rid1), tbl[i].id);
            chk("vec_resp_data", rd1, tbl[i].prod);
            chk("vec_resp_ovf", 32'(rov1), 32'(tbl[i].ovf));
            chk("vec_cnt_hold", 32'(oc1), 32'(prev_cnt));
            rr1 = 1'b1;
            tick();
            rr1 = 1'b0;
            #1;
            chk("vec_done_rv", 32'(rv1), 32'd0);
            chk("vec_done_busy", 32'(busy1), 32'd0);
            chk("vec_cnt", 32'(oc1), 32'(tbl[i].cnt));
            prev_cnt = tbl[i].cnt;
        end

        // Fairness: all valid, response always accepted; rr_ptr is 0 here.
        v1 = 4'hF; rr1 = 1'b1;
        for (int k = 0; k < N; k++) begin
            a1[32*k +: 32] = 32'(k);
            b1[32*k +: 32] = 32'(k);
        end
        mo1 = 32'h3F800000;
        ng = 0; last = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            chk("rr_onehot0", 32'($onehot0(rdy1)), 32'd1);
            if (rdy1 != '0) begin
                if (ng < 6) chk("rr_grant", 32'(rdy1), 32'(4'(1) << exp_ord[ng]));
                if (ng > 0) chk("rr_gap", 32'(c - last), 32'd3);
                last = c;
                ng++;
            end
            tick();
        end
        chk("rr_count", 32'(ng), 32'd6);
        v1 = '0; rr1 = 1'b0;

        // Backpressure: rr_ptr is 2, requester 3 granted, requester 1 waits.
        v1 = 4'b1010;
        a1[32*3 +: 32] = 32'h40000000; b1[32*3 +: 32] = 32'h40000000;
        a1[32*1 +: 32] = 32'h3F800000; b1[32*1 +: 32] = 32'h40800000;
        #1 chk("bp_grant3", 32'(rdy1), 32'h8);
        tick();
        v1 = 4'b0010; mo1 = 32'h11223344;
        tick();
        mo1 = 32'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rv", 32'(rv1), 32'd1);
            chk("bp_data", rd1, 32'h11223344);
            chk("bp_id", 32'(rid1), 32'd3);
            chk("bp_ready", 32'(rdy1), 32'd0);
            tick();
        end
        rr1 = 1'b1;
        #1 chk("bp_ready_hs", 32'(rdy1), 32'd0);
        tick();
        rr1 = 1'b0;
        #1;
        chk("bp_grant1", 32'(rdy1), 32'h2);
        chk("bp_rv_low", 32'(rv1), 32'd0);
        tick();
        v1 = '0; mo1 = 32'h40800000;
        #1 chk("bp_mul_a1", ma1, 32'h3F800000);
        tick();
        #1;
        chk("bp_resp_id1", 32'(rid1), 32'd1);
        chk("bp_resp_data1", rd1, 32'h40800000);
        rr1 = 1'b1;
        tick();
        rr1 = 1'b0;

        // MUL_LAT=3: capture uses mul_out from the third CALC cycle.
        v2 = 4'b0010;
        a2[32*1 +: 32] = 32'h3F800000; b2[32*1 +: 32] = 32'h40000000;
        #1 chk("l3_grant", 32'(rdy2), 32'h2);
        tick();
        v2 = '0; mo2 = 32'hAAAAAAAA;
        #1;
        chk("l3_c1_busy", 32'(busy2), 32'd1);
        chk("l3_c1_a", ma2, 32'h3F800000);
        chk("l3_c1_b", mb2, 32'h40000000);
        tick();
        mo2 = 32'hBBBBBBBB;
        #1;
        chk("l3_c2_a", ma2, 32'h3F800000);
        chk("l3_c2_rv", 32'(rv2), 32'd0);
        tick();
        mo2 = 32'h40000000;
        #1;
        chk("l3_c3_b", mb2, 32'h40000000);
        chk("l3_c3_rv", 32'(rv2), 32'd0);
        tick();
        mo2 = 32'h0;
        #1;
        chk("l3_c4_rv", 32'(rv2), 32'd1);
        chk("l3_c4_data", rd2, 32'h40000000);
        chk("l3_c4_id", 32'(rid2), 32'd1);
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;

        // Saturation of a 2-bit overflow counter.
        op2(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 2'd0, 2'd1);
        op2(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 2'd1, 2'd2);
        op2(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 2'd2, 2'd3);
        op2(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 2'd3, 2'd3);

        // Reset during CALC: result dropped, rr_ptr back to 0.
        v1 = 4'b0100;
        a1[32*2 +: 32] = 32'h40000000; b1[32*2 +: 32] = 32'h40000000;
        #1 chk("rc_grant2", 32'(rdy1), 32'h4);
        tick();
        v1 = '0; mo1 = 32'h40800000; mov1 = 1'b1;
        #1 chk("rc_in_calc", 32'(busy1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mov1 = 1'b0;
        #1;
        chk("rc_busy", 32'(busy1), 32'd0);
        chk("rc_rv", 32'(rv1), 32'd0);
        chk("rc_ovf_count", 32'(oc1), 32'd0);
        chk("rc_ovf_count2", 32'(oc2), 32'd0);
        tick();
        #1 chk("rc_no_resp", 32'(rv1), 32'd0);
        v1 = 4'b1001;
        #1 chk("rc_grant0", 32'(rdy1), 32'h1);
        tick();
        v1 = 4'b1000;
        #1 chk("rc_id0", 32'(rid1), 32'd0);
        tick();
        v1 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
